imem_boot_loader: RTL

- Sequences the writable instruction memory from a byte stream, such as a UART receiver or debug link, before the single-cycle core runs.
- Assembles little-endian 32-bit instruction words, issues one write per word to the instruction-memory write port, and checks the image with an XOR checksum.
- Holds the core stalled until a valid image has been loaded.
- Sits between the byte-stream source and the instruction memory, beside the PC/core reset logic.

---
 rtl/imem_boot_loader_pkg.sv | 19 +
 rtl/imem_boot_loader_byte_packer.sv | 52 +++++
 rtl/imem_boot_loader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/imem_boot_loader_pkg.sv
// Shared definitions for the instruction-memory boot loader.
//   state_e    : loader FSM encoding
//   WORD_BYTES : bytes per instruction word
//   BCNT_W     : width of the byte-within-word counter
package imem_boot_loader_pkg;

  localparam int WORD_BYTES = 4;
  localparam int BCNT_W     = $clog2(WORD_BYTES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_e;

endpackage

// File: rtl/imem_boot_loader_byte_packer.sv
// Little-endian byte-to-word assembler.
//   clk, rst_n : clock, async active-low reset (byte counter only)
//   clr        : restart assembly at byte 0
//   byte_en    : a byte is accepted this cycle
//   byte_in    : the accepted byte
//   word_valid : combinational pulse, this byte completes a word
//   word_out   : the word including byte_in (valid when word_valid=1)
module imem_boot_loader_byte_packer
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic        word_valid,
  output logic [31:0] word_out
);

  logic [BCNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]       asm_q, asm_d;

  // Bytes shift in from the top, so after four bytes the first one sits
  // in bits [7:0].
  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    word_valid = 1'b0;
    word_out   = {byte_in, asm_q[31:8]};
    if (clr) begin
      cnt_d = '0;
    end else if (byte_en) begin
      asm_d      = word_out;
      cnt_d      = cnt_q + 1'b1;
      word_valid = (cnt_q == BCNT_W'(WORD_BYTES - 1));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Assembly data carries no reset; the counter alone defines validity.
  always_ff @(posedge clk) begin
    asm_q <= asm_d;
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Loads the instruction memory from a byte stream before the core runs.
// Stream format: 4-byte little-endian length N (words), N words of 4
// little-endian bytes, then one XOR checksum byte over the data bytes.
//   clk, rst_n   : clock, async active-low reset
//   start        : pulse to begin a load (IDLE/DONE/ERR only)
//   rx_data/valid/ready : byte stream handshake
//   imem_we/waddr/wdata : instruction-memory write port (byte address)
//   core_hold    : stalls the core while 1
//   done, error  : load outcome levels
//   words_loaded : words written in the current or last load
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int DEPTH         = 128,
  parameter bit HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        imem_we,
  output logic [31:0] imem_waddr,
  output logic [31:0] imem_wdata,
  output logic        core_hold,
  output logic        done,
  output logic        error,
  output logic [31:0] words_loaded
);

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);

  state_e      state_q, state_d;
  logic [31:0] len_q, len_d;
  logic [7:0]  csum_q, csum_d;
  logic [31:0] words_loaded_q, words_loaded_d;
  logic        imem_we_q, imem_we_d;
  logic [31:0] imem_waddr_q, imem_waddr_d;
  logic [31:0] imem_wdata_q, imem_wdata_d;
  logic        core_hold_q, core_hold_d;
  logic        done_q, done_d;
  logic        error_q, error_d;

  logic        rx_ready_c;
  logic        byte_xfer;
  logic        start_go;
  logic        pk_en;
  logic        pk_word_valid;
  logic [31:0] pk_word;

  assign rx_ready_c = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
  assign byte_xfer  = rx_valid && rx_ready_c;
  assign pk_en      = byte_xfer && ((state_q == S_LEN) || (state_q == S_DATA));

  imem_boot_loader_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (start_go),
    .byte_en    (pk_en),
    .byte_in    (rx_data),
    .word_valid (pk_word_valid),
    .word_out   (pk_word)
  );

  always_comb begin
    state_d        = state_q;
    len_d          = len_q;
    csum_d         = csum_q;
    words_loaded_d = words_loaded_q;
    imem_we_d      = 1'b0;
    imem_waddr_d   = imem_waddr_q;
    imem_wdata_d   = imem_wdata_q;
    core_hold_d    = core_hold_q;
    done_d         = done_q;
    error_d        = error_q;
    start_go       = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          start_go       = 1'b1;
          state_d        = S_LEN;
          core_hold_d    = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          words_loaded_d = '0;
          csum_d         = '0;
        end
      end
      S_LEN: begin
        if (pk_word_valid) begin
          len_d = pk_word;
          if (pk_word > DEPTH_W) begin
            state_d = S_ERR;
            error_d = 1'b1;
          end else if (pk_word == '0) begin
            state_d = S_CSUM;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (byte_xfer) begin
          csum_d = csum_q ^ rx_data;
        end
        // The write is registered, so it appears one cycle after the
        // word's last byte; the counter advances on that same edge.
        if (pk_word_valid) begin
          imem_we_d      = 1'b1;
          imem_wdata_d   = pk_word;
          imem_waddr_d   = {words_loaded_q[29:0], 2'b00};
          words_loaded_d = words_loaded_q + 32'd1;
          if (words_loaded_q + 32'd1 == len_q) begin
            state_d = S_CSUM;
          end
        end
      end
      S_CSUM: begin
        if (byte_xfer) begin
          if (rx_data == csum_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            core_hold_d = 1'b0;
          end else begin
            state_d = S_ERR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      len_q          <= '0;
      csum_q         <= '0;
      words_loaded_q <= '0;
      imem_we_q      <= 1'b0;
      imem_waddr_q   <= '0;
      imem_wdata_q   <= '0;
      core_hold_q    <= HOLD_AT_RESET;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      len_q          <= len_d;
      csum_q         <= csum_d;
      words_loaded_q <= words_loaded_d;
      imem_we_q      <= imem_we_d;
      imem_waddr_q   <= imem_waddr_d;
      imem_wdata_q   <= imem_wdata_d;
      core_hold_q    <= core_hold_d;
      done_q         <= done_d;
      error_q        <= error_d;
    end
  end

  assign rx_ready     = rx_ready_c;
  assign imem_we      = imem_we_q;
  assign imem_waddr   = imem_waddr_q;
  assign imem_wdata   = imem_wdata_q;
  assign core_hold    = core_hold_q;
  assign done         = done_q;
  assign error        = error_q;
  assign words_loaded = words_loaded_q;

endmodule
